// File: rtl/score_engine_if.sv
// Line-clear event and score/level display bundle between the board logic and score_engine.
interface score_engine_if #(
   parameter int NUM_DIGITS  = 6,
   parameter int LINE_DIGITS = 3,
   parameter int LVL_W       = 5
);
   logic                     i_new_game;
   logic [LVL_W-1:0]         i_start_level;
   logic                     i_update;
   logic [2:0]               i_num_lines;
   logic [4*NUM_DIGITS-1:0]  o_score;
   logic [4*LINE_DIGITS-1:0] o_lines;
   logic [LVL_W-1:0]         o_level;
   logic                     o_busy;
   logic                     o_done;
   logic                     o_saturated;

   modport master (
      output i_new_game, i_start_level, i_update, i_num_lines,
      input  o_score, o_lines, o_level, o_busy, o_done, o_saturated
   );

   modport slave (
      input  i_new_game, i_start_level, i_update, i_num_lines,
      output o_score, o_lines, o_level, o_busy, o_done, o_saturated
   );
endinterface

// File: rtl/score_engine.sv
// BCD score keeper: adds base points (level+1) times, one ripple BCD add per cycle,
// then bumps the BCD line count and the level.
module score_engine #(
   parameter int NUM_DIGITS      = 6,
   parameter int LINE_DIGITS     = 3,
   parameter int LINES_PER_LEVEL = 10,
   parameter int MAX_LEVEL       = 29
) (
   input  logic          i_clk,
   input  logic          i_reset,
   score_engine_if.slave bus
);
   localparam int LVL_W = $clog2(MAX_LEVEL + 1);
   localparam int SW    = 4 * NUM_DIGITS;
   localparam int LW    = 4 * LINE_DIGITS;

   typedef enum logic [1:0] {IDLE, ADD, LINES} state_t;

   state_t           r_state, w_state_next;
   logic [SW-1:0]    r_score, w_score_next;
   logic [LW-1:0]    r_lines, w_lines_next;
   logic [LVL_W-1:0] r_level, w_level_next;
   logic [3:0]       r_progress, w_progress_next;
   logic [15:0]      r_base, w_base_next;
   logic [2:0]       r_nlines, w_nlines_next;
   logic [LVL_W:0]   r_rep, w_rep_next;
   logic             r_busy, w_busy_next;
   logic             r_done, w_done_next;
   logic             r_sat, w_sat_next;

   logic [SW-1:0]       w_base_ext;
   logic [SW-1:0]       w_score_sum;
   logic [NUM_DIGITS:0] w_sc;
   logic [LW-1:0]       w_nl_ext;
   logic [LW-1:0]       w_lines_sum;
   logic [LINE_DIGITS:0] w_lc;
   logic [4:0]          w_prog_sum;
   logic [LVL_W-1:0]    w_start_clamped;
   logic [15:0]         w_base_sel;
   logic                w_nl_valid;

   assign w_base_ext = SW'(r_base);
   assign w_nl_ext   = LW'(r_nlines);
   assign w_sc[0]    = 1'b0;
   assign w_lc[0]    = 1'b0;

   // Digit-serial carry chains; a carry out of the top digit means overflow.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_score_add
         logic [4:0] w_dsum;
         assign w_dsum = 5'(r_score[4*gi +: 4]) + 5'(w_base_ext[4*gi +: 4]) + 5'(w_sc[gi]);
         assign w_sc[gi+1] = (w_dsum > 5'd9);
         assign w_score_sum[4*gi +: 4] = w_sc[gi+1] ? 4'(w_dsum - 5'd10) : w_dsum[3:0];
      end
      for (gi = 0; gi < LINE_DIGITS; gi++) begin : g_lines_add
         logic [4:0] w_dsum;
         assign w_dsum = 5'(r_lines[4*gi +: 4]) + 5'(w_nl_ext[4*gi +: 4]) + 5'(w_lc[gi]);
         assign w_lc[gi+1] = (w_dsum > 5'd9);
         assign w_lines_sum[4*gi +: 4] = w_lc[gi+1] ? 4'(w_dsum - 5'd10) : w_dsum[3:0];
      end
   endgenerate

   assign w_prog_sum      = 5'(r_progress) + 5'(r_nlines);
   assign w_start_clamped = (bus.i_start_level > LVL_W'(MAX_LEVEL)) ? LVL_W'(MAX_LEVEL)
                                                                    : bus.i_start_level;

   always_comb begin
      w_base_sel = 16'h0000;
      w_nl_valid = 1'b1;
      case (bus.i_num_lines)
         3'd1:    w_base_sel = 16'h0040;
         3'd2:    w_base_sel = 16'h0100;
         3'd3:    w_base_sel = 16'h0300;
         3'd4:    w_base_sel = 16'h1200;
         default: w_nl_valid = 1'b0;
      endcase
   end

   always_comb begin
      w_state_next    = r_state;
      w_score_next    = r_score;
      w_lines_next    = r_lines;
      w_level_next    = r_level;
      w_progress_next = r_progress;
      w_base_next     = r_base;
      w_nlines_next   = r_nlines;
      w_rep_next      = r_rep;
      w_busy_next     = r_busy;
      w_done_next     = 1'b0;
      w_sat_next      = r_sat;
      if (bus.i_new_game) begin
         w_state_next    = IDLE;
         w_score_next    = '0;
         w_lines_next    = '0;
         w_progress_next = '0;
         w_sat_next      = 1'b0;
         w_busy_next     = 1'b0;
         w_level_next    = w_start_clamped;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.i_update && w_nl_valid) begin
                  w_base_next   = w_base_sel;
                  w_nlines_next = bus.i_num_lines;
                  w_rep_next    = {1'b0, r_level} + 1'b1;
                  w_busy_next   = 1'b1;
                  w_state_next  = ADD;
               end
            end
            ADD: begin
               if (!r_sat) begin
                  if (w_sc[NUM_DIGITS]) begin
                     w_score_next = {NUM_DIGITS{4'h9}};
                     w_sat_next   = 1'b1;
                  end else begin
                     w_score_next = w_score_sum;
                  end
               end
               w_rep_next = r_rep - 1'b1;
               if (r_rep == {{LVL_W{1'b0}}, 1'b1}) w_state_next = LINES;
            end
            LINES: begin
               w_lines_next = w_lc[LINE_DIGITS] ? {LINE_DIGITS{4'h9}} : w_lines_sum;
               if (w_prog_sum >= 5'(LINES_PER_LEVEL)) begin
                  w_progress_next = 4'(w_prog_sum - 5'(LINES_PER_LEVEL));
                  if (r_level != LVL_W'(MAX_LEVEL)) w_level_next = r_level + 1'b1;
               end else begin
                  w_progress_next = w_prog_sum[3:0];
               end
               w_busy_next  = 1'b0;
               w_done_next  = 1'b1;
               w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= IDLE;
         r_score    <= '0;
         r_lines    <= '0;
         r_level    <= '0;
         r_progress <= '0;
         r_base     <= '0;
         r_nlines   <= '0;
         r_rep      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_sat      <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_score    <= w_score_next;
         r_lines    <= w_lines_next;
         r_level    <= w_level_next;
         r_progress <= w_progress_next;
         r_base     <= w_base_next;
         r_nlines   <= w_nlines_next;
         r_rep      <= w_rep_next;
         r_busy     <= w_busy_next;
         r_done     <= w_done_next;
         r_sat      <= w_sat_next;
      end
   end

   assign bus.o_score     = r_score;
   assign bus.o_lines     = r_lines;
   assign bus.o_level     = r_level;
   assign bus.o_busy      = r_busy;
   assign bus.o_done      = r_done;
   assign bus.o_saturated = r_sat;
endmodule

// File: tb/tb_score_engine.sv
// Drives a 6-digit and a 4-digit score_engine with identical events and checks both
// against an integer-arithmetic model of the scoring rules.
module tb_score_engine;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       new_game = 1'b0;
   logic       update = 1'b0;
   logic [4:0] start_level = 5'd0;
   logic [2:0] num_lines = 3'd0;

   always #5 clk = ~clk;

   score_engine_if #(.NUM_DIGITS(6), .LINE_DIGITS(3), .LVL_W(5)) if6 ();
   score_engine_if #(.NUM_DIGITS(4), .LINE_DIGITS(3), .LVL_W(5)) if4 ();

   assign if6.i_new_game    = new_game;
   assign if6.i_start_level = start_level;
   assign if6.i_update      = update;
   assign if6.i_num_lines   = num_lines;
   assign if4.i_new_game    = new_game;
   assign if4.i_start_level = start_level;
   assign if4.i_update      = update;
   assign if4.i_num_lines   = num_lines;

   score_engine #(.NUM_DIGITS(6), .LINE_DIGITS(3), .LINES_PER_LEVEL(10), .MAX_LEVEL(29))
      u_dut6 (.i_clk(clk), .i_reset(reset), .bus(if6));
   score_engine #(.NUM_DIGITS(4), .LINE_DIGITS(3), .LINES_PER_LEVEL(10), .MAX_LEVEL(29))
      u_dut4 (.i_clk(clk), .i_reset(reset), .bus(if4));

   int     n_checks = 0;
   int     n_errors = 0;
   longint m_total  = 0;
   int     m_lines  = 0;
   int     m_level  = 0;
   int     m_prog   = 0;

   typedef struct {
      bit          ng;
      int          start;
      int          nl;
      logic [23:0] exp_score;
      logic [11:0] exp_lines;
      int          exp_level;
   } vec_t;
   vec_t vecs [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] to_bcd(input longint v, input int nd);
      logic [63:0] r;
      longint lim, x;
      r = '0;
      lim = 1;
      for (int i = 0; i < nd; i++) lim = lim * 10;
      x = (v > lim - 1) ? lim - 1 : v;
      for (int i = 0; i < nd; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic int base_pts(input int n);
      case (n)
         1: return 40;
         2: return 100;
         3: return 300;
         4: return 1200;
         default: return 0;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".score6"}, 64'(if6.o_score), to_bcd(m_total, 6));
      check({tag, ".score4"}, 64'(if4.o_score), to_bcd(m_total, 4));
      check({tag, ".lines6"}, 64'(if6.o_lines), to_bcd(longint'(m_lines), 3));
      check({tag, ".lines4"}, 64'(if4.o_lines), to_bcd(longint'(m_lines), 3));
      check({tag, ".level6"}, 64'(if6.o_level), 64'(m_level));
      check({tag, ".level4"}, 64'(if4.o_level), 64'(m_level));
      check({tag, ".sat6"}, 64'(if6.o_saturated), 64'(m_total > 999999));
      check({tag, ".sat4"}, 64'(if4.o_saturated), 64'(m_total > 9999));
      check({tag, ".busy"}, 64'(if6.o_busy), 64'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      m_total = 0; m_lines = 0; m_level = 0; m_prog = 0;
      check_outputs("reset");
      check("reset.done", 64'(if6.o_done), 64'd0);
      $display("reset: score=%h lines=%h level=%0d", if6.o_score, if6.o_lines, if6.o_level);
   endtask

   task automatic do_new_game(input int s);
      new_game = 1'b1;
      start_level = 5'(s);
      step();
      new_game = 1'b0;
      m_total = 0; m_lines = 0; m_prog = 0;
      m_level = (s > 29) ? 29 : s;
      check_outputs("new_game");
      check("new_game.done", 64'(if6.o_done), 64'd0);
      $display("new_game start=%0d: level=%0d score=%h", s, if6.o_level, if6.o_score);
   endtask

   // glitch_at > 0 raises update again on that busy cycle; it must be dropped.
   task automatic do_event(input int n, input int glitch_at);
      int cnt;
      int exp_busy;
      exp_busy = m_level + 2;
      update = 1'b1;
      num_lines = 3'(n);
      step();
      update = 1'b0;
      check("accept.done_low", 64'(if6.o_done), 64'd0);
      if (n < 1 || n > 4) begin
         check("ignored.busy", 64'(if6.o_busy), 64'd0);
         check_outputs("ignored");
         $display("event n=%0d ignored: score=%h busy=%0d", n, if6.o_score, if6.o_busy);
      end else begin
         cnt = 0;
         while (if6.o_busy && cnt < 64) begin
            cnt++;
            if (cnt == glitch_at) update = 1'b1;
            step();
            update = 1'b0;
         end
         check("busy_cycles", 64'(cnt), 64'(exp_busy));
         check("done6", 64'(if6.o_done), 64'd1);
         check("done4", 64'(if4.o_done), 64'd1);
         m_total = m_total + longint'(base_pts(n)) * longint'(m_level + 1);
         m_lines = (m_lines + n > 999) ? 999 : m_lines + n;
         m_prog  = m_prog + n;
         if (m_prog >= 10) begin
            m_prog = m_prog - 10;
            if (m_level < 29) m_level++;
         end
         check_outputs("event");
         $display("event n=%0d busy=%0d: score6=%h score4=%h lines=%h level=%0d sat4=%0d",
                  n, cnt, if6.o_score, if4.o_score, if6.o_lines, if6.o_level, if4.o_saturated);
      end
   endtask

   initial begin
      vecs[0] = '{ng: 1'b0, start: 0,  nl: 1, exp_score: 24'h000040, exp_lines: 12'h001, exp_level: 0};
      vecs[1] = '{ng: 1'b1, start: 2,  nl: 4, exp_score: 24'h003600, exp_lines: 12'h004, exp_level: 2};
      vecs[2] = '{ng: 1'b1, start: 31, nl: 1, exp_score: 24'h001200, exp_lines: 12'h001, exp_level: 29};
      vecs[3] = '{ng: 1'b1, start: 0,  nl: 2, exp_score: 24'h000100, exp_lines: 12'h002, exp_level: 0};
      vecs[4] = '{ng: 1'b0, start: 0,  nl: 3, exp_score: 24'h000400, exp_lines: 12'h005, exp_level: 0};
      vecs[5] = '{ng: 1'b0, start: 0,  nl: 4, exp_score: 24'h001600, exp_lines: 12'h009, exp_level: 0};
      vecs[6] = '{ng: 1'b0, start: 0,  nl: 1, exp_score: 24'h001640, exp_lines: 12'h010, exp_level: 1};
      vecs[7] = '{ng: 1'b0, start: 0,  nl: 1, exp_score: 24'h001720, exp_lines: 12'h011, exp_level: 1};

      step();
      do_reset();

      foreach (vecs[i]) begin
         if (vecs[i].ng) do_new_game(vecs[i].start);
         do_event(vecs[i].nl, -1);
         check("vec.score", 64'(if6.o_score), 64'(vecs[i].exp_score));
         check("vec.lines", 64'(if6.o_lines), 64'(vecs[i].exp_lines));
         check("vec.level", 64'(if6.o_level), 64'(vecs[i].exp_level));
      end

      // ten single lines at level 0, then one at level 1
      do_new_game(0);
      for (int i = 0; i < 10; i++) do_event(1, -1);
      check("ten.score", 64'(if6.o_score), 64'h000400);
      check("ten.lines", 64'(if6.o_lines), 64'h010);
      check("ten.level", 64'(if6.o_level), 64'd1);
      do_event(1, -1);
      check("ten.next", 64'(if6.o_score), 64'h000480);

      // 4-digit instance overflows while the 6-digit one keeps counting
      do_new_game(2);
      do_event(4, -1);
      do_event(4, -1);
      do_event(1, -1);
      do_event(1, -1);
      check("presat.score4", 64'(if4.o_score), 64'h7440);
      do_event(4, -1);
      check("sat.score4", 64'(if4.o_score), 64'h9999);
      check("sat.flag4", 64'(if4.o_saturated), 64'd1);
      check("sat.score6", 64'(if6.o_score), 64'h012240);
      do_event(2, -1);
      do_event(2, -1);
      check("sat.hold4", 64'(if4.o_score), 64'h9999);
      check("sat.lines4", 64'(if4.o_lines), 64'h018);

      // a second update during busy is dropped
      do_new_game(5);
      do_event(3, 3);
      check("drop.score", 64'(if6.o_score), 64'h001800);
      step();
      check("drop.busy", 64'(if6.o_busy), 64'd0);

      // invalid line counts
      do_event(0, -1);
      do_event(6, -1);
      do_event(7, -1);

      // new_game aborts an in-flight event
      do_new_game(10);
      update = 1'b1; num_lines = 3'd4;
      step();
      update = 1'b0;
      step();
      step();
      check("abort.busy_mid", 64'(if6.o_busy), 64'd1);
      do_new_game(0);
      step();
      check("abort.no_done", 64'(if6.o_done), 64'd0);
      check("abort.score", 64'(if6.o_score), 64'd0);

      // reset aborts an in-flight event
      do_new_game(3);
      do_event(2, -1);
      update = 1'b1; num_lines = 3'd4;
      step();
      update = 1'b0;
      step();
      do_reset();
      step();
      check("rst.no_done", 64'(if6.o_done), 64'd0);

      // random events, occasional new games and dropped re-triggers
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 19) == 0) do_new_game(int'($urandom_range(0, 31)));
         else do_event(int'($urandom_range(0, 7)),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : -1);
      end

      // drive lines, level and the 6-digit score into saturation
      do_new_game(0);
      for (int i = 0; i < 260; i++) do_event(4, -1);
      check("full.lines", 64'(if6.o_lines), 64'h999);
      check("full.level", 64'(if6.o_level), 64'd29);
      check("full.score6", 64'(if6.o_score), 64'h999999);
      check("full.sat6", 64'(if6.o_saturated), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
